// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall vectors, memory FSM states,
// stage indices and the stall priority encoder.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W = 6;

    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    // A stall source freezes its own stage and everything upstream of it.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WAIT = 2'd1,
        M_TRAP = 2'd2
    } mem_state_e;

    // Trap releases everything so the flush can propagate; then MEM > EX > ID.
    function automatic logic [STALL_W-1:0] stall_encode(
        input logic trap,
        input logic mem_req,
        input logic ex_req,
        input logic id_req
    );
        logic [STALL_W-1:0] s;
        if (trap) begin
            s = STALL_NONE;
        end else if (mem_req) begin
            s = STALL_MEM;
        end else if (ex_req) begin
            s = STALL_EX;
        end else if (id_req) begin
            s = STALL_ID;
        end else begin
            s = STALL_NONE;
        end
        return s;
    endfunction

endpackage

// File: rtl/ex_busy_cnt.sv
// Multi-cycle EX scheduler: accepts one start per EX occupancy and counts the
// extra cycles the op holds the EX stage.
module ex_busy_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             ex_advance,
    input  logic             trap_clr,
    output logic             ex_stall_req_c,
    output logic             ex_busy_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             start_seen_q;
    logic             start_seen_d;
    logic             accept_c;

    // start_seen blocks a held op from re-triggering while EX is frozen downstream.
    always_comb begin
        cnt_d          = cnt_q;
        start_seen_d   = start_seen_q;
        accept_c       = start && (len != '0) && (cnt_q == '0) && !start_seen_q;
        ex_busy_c      = (cnt_q != '0);
        ex_stall_req_c = accept_c || (cnt_q != '0);

        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (ex_advance) begin
            start_seen_d = 1'b0;
        end
        if (accept_c) begin
            cnt_d        = len - CNT_W'(1);
            start_seen_d = 1'b1;
        end
        if (trap_clr) begin
            cnt_d        = '0;
            start_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            start_seen_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            start_seen_q <= start_seen_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates ID/EX/MEM stall sources into the stage stall
// vector and converts a memory access timeout into a trap flush.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    parameter int unsigned CNT_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               idStallReq,
    input  logic               exMultiStart,
    input  logic [CNT_W-1:0]   exMultiLen,
    input  logic               memReq,
    input  logic               memAck,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        newPC,
    output logic               exBusy,
    output logic               memTimeout
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    mem_state_e         state_q;
    mem_state_e         state_d;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [WAIT_W-1:0]  wait_cnt_d;
    logic               mem_stall_c;
    logic               trap_c;
    logic               ex_stall_req_c;
    logic               ex_busy_c;
    logic [STALL_W-1:0] stall_c;

    ex_busy_cnt #(
        .CNT_W(CNT_W)
    ) u_ex_busy_cnt (
        .clk           (clk),
        .rst           (rst),
        .start         (exMultiStart),
        .len           (exMultiLen),
        .ex_advance    (!stall_c[STG_EX]),
        .trap_clr      (trap_c),
        .ex_stall_req_c(ex_stall_req_c),
        .ex_busy_c     (ex_busy_c)
    );

    // Memory wait-state tracker; an ack in the final wait cycle beats the timeout.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_stall_c = 1'b0;
        trap_c      = (state_q == M_TRAP);

        unique case (state_q)
            M_IDLE: begin
                if (memReq && !memAck) begin
                    mem_stall_c = 1'b1;
                    state_d     = M_WAIT;
                    wait_cnt_d  = WAIT_W'(1);
                end else begin
                    wait_cnt_d  = '0;
                end
            end
            M_WAIT: begin
                if (memAck || !memReq) begin
                    state_d    = M_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    mem_stall_c = 1'b1;
                    if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d    = M_TRAP;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            M_TRAP: begin
                state_d    = M_IDLE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = M_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_c = stall_encode(trap_c, mem_stall_c, ex_stall_req_c, idStallReq);
    end

    // Every output is held low while reset is asserted, independent of inputs.
    always_comb begin
        stall      = STALL_NONE;
        flush      = 1'b0;
        newPC      = '0;
        exBusy     = 1'b0;
        memTimeout = 1'b0;
        if (!rst) begin
            stall      = stall_c;
            flush      = trap_c;
            memTimeout = trap_c;
            newPC      = trap_c ? TRAP_VEC : 32'h0;
            exBusy     = ex_busy_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= M_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the 5-stage core. Produces the 6-bit `stall` vector that every stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) consumes, and schedules three stall sources: ID load-use hazards, multi-cycle EX operations and data-memory wait states. It also raises a trap flush when a memory access times out. The bubble rule is fixed: stage register n→n+1 holds when `stall[n]`=1, and inserts a bubble when `stall[n+1:n]`==2'b01.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: maximum number of stall cycles for one memory access before a trap.
- `TRAP_VEC`, default 32'h0000_0100: PC loaded on a timeout flush.
- `CNT_W`, default 6: width of the multi-cycle length and counter.

Ports:
- `clk`  in  1: the single clock; all state updates on posedge.
- `rst`  in  1: asynchronous, active-high reset.
- `idStallReq`  in  1: load-use hazard detected in ID.
- `exMultiStart`  in  1: the op currently in EX is multi-cycle.
- `exMultiLen`  in  CNT_W: number of extra cycles the op holds EX. 0 means single-cycle.
- `memReq`  in  1: the MEM stage is performing a load or store.
- `memAck`  in  1: data memory completes the access this cycle.
- `stall`  out  6: bit 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
- `flush`  out  1: kill all in-flight instructions.
- `newPC`  out  32: redirect target, valid when `flush`=1.
- `exBusy`  out  1: the multi-cycle counter is non-zero.
- `memTimeout`  out  1: one-cycle pulse when an access is abandoned.

## Operation
- Stall priority, combinational:
  - Trap: `stall`=0.
  - Memory stall: 6'b011111.
  - EX stall: 6'b001111.
  - ID stall: 6'b000111.
  - Otherwise: 0.
- EX scheduler:
  - A start is accepted when `exMultiStart`=1, `exMultiLen`≠0, `cnt`==0 and `startSeen`=0.
  - On acceptance: the EX stall request is asserted that cycle; on the edge, `cnt`←len−1 and `startSeen`←1.
  - While `cnt`≠0: EX stall request = 1 and `cnt` decrements every edge. The counter keeps running while MEM stalls.
  - `startSeen` clears on any edge where `stall[3]`=0, i.e. when EX advances. This prevents a held op from restarting while EX is frozen by a memory stall.
- Memory FSM, states M_IDLE, M_WAIT, M_TRAP:
  - M_IDLE: if `memReq` & !`memAck`, assert the memory stall and go to M_WAIT with `waitCnt`←1. Otherwise no memory stall.
  - M_WAIT, `memAck`=1: no stall this cycle; go to M_IDLE.
  - M_WAIT, `memReq`=0: no stall; go to M_IDLE.
  - M_WAIT, neither of the above: stall. If `waitCnt`==MEM_TIMEOUT−1, go to M_TRAP; otherwise increment `waitCnt`.
  - M_TRAP: `flush`=1, `newPC`=TRAP_VEC, `memTimeout`=1, `stall`=0. On the edge: clear `cnt` and `startSeen`, then go to M_IDLE.
- `newPC`=0 whenever `flush`=0.
- `exBusy` = (`cnt`≠0).

## Timing
- Reset, asynchronous: state M_IDLE, `cnt`=0, `waitCnt`=0, `startSeen`=0. Outputs `stall`=0, `flush`=0, `newPC`=0, `exBusy`=0, `memTimeout`=0. All outputs are forced to 0 while `rst`=1, regardless of inputs.
- Stall outputs are combinational from registered state plus the current inputs (zero-cycle latency). Registered state changes on posedge.
- Multi-cycle op with len L starting in cycle t:
  - EX stall is asserted in cycles t … t+L−1.
  - EX advances at the end of cycle t+L.
  - `exBusy` is high in cycles t+1 … t+L−1.
- Memory access never acked:
  - Stall is asserted for exactly MEM_TIMEOUT cycles.
  - The next cycle is M_TRAP, with a 1-cycle `flush`.
- Simultaneous `memAck` and timeout count: the ack wins; no trap.
- Simultaneous ID, EX and MEM requests: the priority above applies; lower requests stay pending because their inputs are held.
- Reset mid-operation: the FSM and counters abort immediately and no trap is signalled.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the stall encodings STALL_NONE, STALL_ID, STALL_EX, STALL_MEM;
  - the memory FSM state enum;
  - the stage index constants PC..WB.
- One sub-module, `ex_busy_cnt`: accepts starts, holds `cnt` and `startSeen`, and outputs the EX stall request and `exBusy`. The memory FSM and priority mux stay in `pipe_ctrl`.

## Test plan
- Reset with `idStallReq`=1 asserted → `stall`=0. Release reset, `idStallReq`=1 → `stall`=6'b000111.
- `exMultiStart`=1, `exMultiLen`=3 in cycle t → `stall`=6'b001111 in t, t+1, t+2; 0 in t+3. `exBusy` high in t+1 and t+2.
- `memReq`=1, `memAck` at cycle 4 of the access → `stall`=6'b011111 for cycles 1–3, 0 in cycle 4, no flush.
- `memReq`=1 with `memAck`=0 held and MEM_TIMEOUT=16 → 16 stall cycles, then `flush`=1, `newPC`=32'h100, `memTimeout`=1 for one cycle, then `stall`=0.
- Multi-cycle op (len=2) overlapping a 5-cycle memory stall with `exMultiStart` held → `stall`=6'b011111 for 5 cycles, no restart, `cnt` reaches 0, and EX advances at the first non-stalled edge.
- Assert `rst` mid-M_WAIT with `cnt`=4 → all outputs 0 immediately; after release, FSM in M_IDLE and `exBusy`=0.
